// File: rtl/pipemem_io_param.sv
// MEM-stage data memory plus memory-mapped I/O: output regs, synchronised inputs, W1C STATUS, MASK, free-running COUNT.
// Reads are combinational from malu; writes take effect on the rising edge; no backpressure (single-cycle accept).
module pipemem_io_param #(
  parameter int ADDR_W     = 5,
  parameter int N_OUT      = 3,
  parameter int N_IN       = 2,
  parameter int IO_SEL_BIT = 7
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                mwmem,
  input  logic [31:0]         malu,
  input  logic [31:0]         mb,
  input  logic [N_IN*32-1:0]  in_ports,
  output logic [31:0]         mmo,
  output logic [N_OUT*32-1:0] out_ports,
  output logic                irq
);

  localparam int         DEPTH       = 1 << ADDR_W;
  localparam logic [4:0] SLOT_STATUS = 5'd16;
  localparam logic [4:0] SLOT_MASK   = 5'd17;
  localparam logic [4:0] SLOT_COUNT  = 5'd18;

  logic              io;
  logic [4:0]        slot;
  logic [ADDR_W-1:0] widx;
  logic              mem_we;
  logic              io_we;

  logic [31:0]             mem_q [DEPTH];
  logic [N_OUT-1:0][31:0]  out_q, out_d;
  logic [N_IN-1:0][31:0]   sync1_q, sync2_q, hist_q;
  logic [N_IN-1:0]         status_q, status_d, status_clr, chg;
  logic [N_IN-1:0]         mask_q, mask_d;
  logic [31:0]             count_q, count_d;
  logic                    irq_q, irq_d;
  logic [31:0]             rdata;
  logic                    unused_bits;

  assign io     = malu[IO_SEL_BIT];
  assign slot   = malu[6:2];
  assign widx   = malu[ADDR_W+1:2];
  assign mem_we = mwmem & ~io;
  assign io_we  = mwmem & io;

  assign unused_bits = ^malu;

  // Data memory is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[widx] <= mb;
  end

  always_comb begin
    out_d = out_q;
    for (int k = 0; k < N_OUT; k++) begin
      if (io_we && slot == 5'(k)) out_d[k] = mb;
    end
    for (int k = 0; k < N_IN; k++) begin
      chg[k] = (sync2_q[k] != hist_q[k]);
    end
    status_clr = (io_we && slot == SLOT_STATUS) ? mb[N_IN-1:0] : '0;
    // A change seen on the same edge as a clear keeps the bit set.
    status_d   = (status_q & ~status_clr) | chg;
    mask_d     = (io_we && slot == SLOT_MASK) ? mb[N_IN-1:0] : mask_q;
    // The counter also ticks on the load edge, so readback starts at mb+1.
    count_d    = (io_we && slot == SLOT_COUNT) ? mb + 32'd1 : count_q + 32'd1;
    irq_d      = |(status_q & mask_q);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      hist_q   <= '0;
      status_q <= '0;
      mask_q   <= '0;
      count_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      sync1_q  <= in_ports;
      sync2_q  <= sync1_q;
      hist_q   <= sync2_q;
      status_q <= status_d;
      mask_q   <= mask_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (!io) begin
      rdata = mem_q[widx];
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (slot == 5'(k)) rdata = out_q[k];
      end
      for (int k = 0; k < N_IN; k++) begin
        if (slot == 5'(8 + k)) rdata = sync2_q[k];
      end
      if (slot == SLOT_STATUS) rdata = 32'(status_q);
      if (slot == SLOT_MASK)   rdata = 32'(mask_q);
      if (slot == SLOT_COUNT)  rdata = count_q;
    end
  end

  assign mmo       = rdata;
  assign out_ports = out_q;
  assign irq       = irq_q;

endmodule
